// File: rtl/ball_vertical_velocity_pkg.sv
// ball_vertical_velocity_pkg: shared load constant, direction/velocity types and paddle-segment velocity lookup
package ball_vertical_velocity_pkg;
  localparam logic [3:0] STILL_LOAD_DEF = 4'd8;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
  typedef struct packed {
    dir_e       dir;
    logic [1:0] mag;
  } vel_t;
  function automatic vel_t seg_to_vel(input logic [2:0] vpad);
    vel_t v;
    v.dir = vpad[2] ? DIR_DOWN : DIR_UP;
    v.mag = vpad[2] ? vpad[1:0] : ~vpad[1:0];
    return v;
  endfunction
  function automatic logic [3:0] load_of(input logic [3:0] still, input vel_t v);
    return (v.dir == DIR_UP) ? still + {2'b00, v.mag} : still - {2'b00, v.mag};
  endfunction
endpackage

// File: rtl/ball_vertical_velocity_if.sv
// ball_vertical_velocity_if: game-side inputs and load-nibble outputs of the vertical velocity block
interface ball_vertical_velocity_if;
  logic       hit;
  logic [2:0] vpad;
  logic       vvid;
  logic       _vblank;
  logic       serve;
  logic       ab, bb, cb, db;
  logic       vdir;
  logic [1:0] vmag;
  modport master (output hit, vpad, vvid, _vblank, serve, input ab, bb, cb, db, vdir, vmag);
  modport slave (input hit, vpad, vvid, _vblank, serve, output ab, bb, cb, db, vdir, vmag);
endinterface

// File: rtl/ball_vertical_velocity_edge_detect.sv
// ball_vertical_velocity_edge_detect: registered rise/fall strobes of an in-domain level
module ball_vertical_velocity_edge_detect #(
  parameter logic IDLE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);
  logic r_prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_prev <= IDLE;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      r_prev <= i_d;
      o_rise <= i_d & ~r_prev;
      o_fall <= ~i_d & r_prev;
    end
endmodule

// File: rtl/ball_vertical_velocity.sv
// ball_vertical_velocity: tracks ball vertical direction/speed and loads the counter nibble at vblank start
module ball_vertical_velocity
  import ball_vertical_velocity_pkg::*;
#(
  parameter logic [3:0] STILL_LOAD = STILL_LOAD_DEF
) (
  input logic                     clk7_159,
  input logic                     _rst,
  ball_vertical_velocity_if.slave bus
);
  logic       w_hit_rise, w_serve_rise, w_vb_rise, w_vb_fall, w_hit, w_wall;
  logic [1:0] w_unused_fall;
  logic       r_wall, r_hit_armed, r_wall_armed;
  vel_t       r_seg, r_pend, r_appl, w_pend_nx;
  logic [3:0] r_load;
  ball_vertical_velocity_edge_detect #(.IDLE(1'b0)) u_hit_ed (
    .clk(clk7_159), .rst_n(_rst), .i_d(bus.hit), .o_rise(w_hit_rise), .o_fall(w_unused_fall[0])
  );
  ball_vertical_velocity_edge_detect #(.IDLE(1'b0)) u_serve_ed (
    .clk(clk7_159), .rst_n(_rst), .i_d(bus.serve), .o_rise(w_serve_rise), .o_fall(w_unused_fall[1])
  );
  ball_vertical_velocity_edge_detect #(.IDLE(1'b1)) u_vblank_ed (
    .clk(clk7_159), .rst_n(_rst), .i_d(bus._vblank), .o_rise(w_vb_rise), .o_fall(w_vb_fall)
  );
  // wall and paddle segment are registered so every event lines up with the edge strobes
  assign w_hit  = w_hit_rise & r_hit_armed;
  assign w_wall = r_wall & r_wall_armed & ~w_hit;
  always_comb begin
    w_pend_nx.dir = w_hit ? r_seg.dir : w_wall ? dir_e'(~r_pend.dir) : r_pend.dir;
    w_pend_nx.mag = w_serve_rise ? 2'd0 : w_hit ? r_seg.mag : r_pend.mag;
  end
  always_ff @(posedge clk7_159 or negedge _rst)
    if (!_rst) begin
      r_wall       <= 1'b0;
      r_seg        <= '0;
      r_pend       <= '0;
      r_appl       <= '0;
      r_load       <= STILL_LOAD;
      r_hit_armed  <= 1'b1;
      r_wall_armed <= 1'b1;
    end else begin
      r_wall       <= bus.vvid & ~bus._vblank;
      r_seg        <= seg_to_vel(bus.vpad);
      r_pend       <= w_pend_nx;
      r_hit_armed  <= ~w_hit & (w_vb_rise | r_hit_armed);
      r_wall_armed <= ~(w_hit | w_wall) & (w_vb_rise | r_wall_armed);
      if (w_vb_fall) begin
        r_appl <= r_pend;
        r_load <= load_of(STILL_LOAD, r_pend);
      end
    end
  assign {bus.db, bus.cb, bus.bb, bus.ab} = r_load;
  assign bus.vdir = r_appl.dir;
  assign bus.vmag = r_appl.mag;
endmodule

// File: tb/tb_ball_vertical_velocity.sv
// tb_ball_vertical_velocity: directed frame scenarios plus random frames against a behavioural velocity model
module tb_ball_vertical_velocity;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  ball_vertical_velocity_if bus();
  ball_vertical_velocity dut (.clk7_159(clk), ._rst(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [6:0] obs;
  assign obs = {bus.vdir, bus.vmag, bus.db, bus.cb, bus.bb, bus.ab};
  int m_dir_p, m_mag_p, m_vdir, m_vmag, m_load, e_vp;
  bit m_hit_arm, m_wall_arm, p_hit, p_serve, p_vb;
  bit e_hit, e_serve, e_wall, e_fall, e_rise;
  function automatic int load_val(int dir, int mag);
    return dir != 0 ? (8 + mag) % 16 : (8 - mag + 16) % 16;
  endfunction
  task automatic model_reset();
    m_dir_p = 0; m_mag_p = 0; m_vdir = 0; m_vmag = 0; m_load = 8;
    m_hit_arm = 1; m_wall_arm = 1;
    p_hit = 0; p_serve = 0; p_vb = 1;
    e_hit = 0; e_serve = 0; e_wall = 0; e_fall = 0; e_rise = 0; e_vp = 0;
  endtask
  task automatic tick();
    bit hit_t, wall_t;
    logic [6:0] exp_v;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      if (e_fall) begin
        m_vdir = m_dir_p; m_vmag = m_mag_p; m_load = load_val(m_dir_p, m_mag_p);
      end
      hit_t  = e_hit && m_hit_arm;
      wall_t = e_wall && m_wall_arm && !hit_t;
      if (hit_t) m_dir_p = (e_vp < 4) ? 1 : 0;
      else if (wall_t) m_dir_p = 1 - m_dir_p;
      if (e_serve) m_mag_p = 0;
      else if (hit_t) m_mag_p = (e_vp < 4) ? 3 - e_vp : e_vp - 4;
      if (e_rise) begin m_hit_arm = 1; m_wall_arm = 1; end
      if (hit_t) begin m_hit_arm = 0; m_wall_arm = 0; end
      if (wall_t) m_wall_arm = 0;
      e_hit   = bus.hit && !p_hit;
      e_vp    = int'(bus.vpad);
      e_serve = bus.serve && !p_serve;
      e_fall  = !bus._vblank && p_vb;
      e_rise  = bus._vblank && !p_vb;
      e_wall  = bus.vvid && !bus._vblank;
      p_hit = bus.hit; p_serve = bus.serve; p_vb = bus._vblank;
    end
    #1;
    exp_v = {m_vdir[0], m_vmag[1:0], m_load[3:0]};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL model_tick t=%0t got {vdir,vmag,load}=%b exp %b", $time, obs, exp_v);
    end
  endtask
  // 20-cycle frame: active lines 0..13, vblank 14..19
  task automatic frame(input int ha, input int hb, input logic [2:0] va, input logic [2:0] vb,
                       input int w0, input int wn, input int sv);
    for (int c = 0; c < 20; c++) begin
      bus._vblank = (c < 14);
      bus.hit     = (c == ha) || (c == hb);
      bus.vpad    = (c == hb) ? vb : va;
      bus.vvid    = (c >= w0) && (c < w0 + wn);
      bus.serve   = (c == sv);
      tick();
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    frame(-1, -1, 3'd0, 3'd0, -1, 0, -1);
    frame(-1, -1, 3'd0, 3'd0, -1, 0, -1);
    checks++;
    if (obs !== {1'b0, 2'd0, 4'd8}) begin
      failures++; $display("FAIL reset_idle got %b exp %b", obs, {1'b0, 2'd0, 4'd8});
    end
  endtask
  task automatic test_hit_apply();
    frame(5, -1, 3'd1, 3'd0, -1, 0, -1);
    checks++;
    if (obs !== {1'b1, 2'd2, 4'd10}) begin
      failures++; $display("FAIL hit_vpad1 got %b exp %b", obs, {1'b1, 2'd2, 4'd10});
    end
    frame(5, -1, 3'd7, 3'd0, -1, 0, -1);
    checks++;
    if (obs !== {1'b0, 2'd3, 4'd5}) begin
      failures++; $display("FAIL hit_vpad7 got %b exp %b", obs, {1'b0, 2'd3, 4'd5});
    end
  endtask
  task automatic test_wall();
    frame(3, -1, 3'd0, 3'd0, -1, 0, -1);
    frame(-1, -1, 3'd0, 3'd0, 15, 4, -1);
    checks++;
    if (obs !== {1'b1, 2'd3, 4'd11}) begin
      failures++; $display("FAIL wall_not_yet got %b exp %b", obs, {1'b1, 2'd3, 4'd11});
    end
    frame(-1, -1, 3'd0, 3'd0, -1, 0, -1);
    checks++;
    if (obs !== {1'b0, 2'd3, 4'd5}) begin
      failures++; $display("FAIL wall_single_toggle got %b exp %b", obs, {1'b0, 2'd3, 4'd5});
    end
  endtask
  task automatic test_double_hit();
    frame(3, 8, 3'd0, 3'd6, -1, 0, -1);
    checks++;
    if (obs !== {1'b1, 2'd3, 4'd11}) begin
      failures++; $display("FAIL first_hit_only got %b exp %b", obs, {1'b1, 2'd3, 4'd11});
    end
    frame(16, -1, 3'd5, 3'd0, 16, 1, -1);
    frame(-1, -1, 3'd0, 3'd0, -1, 0, -1);
    checks++;
    if (obs !== {1'b0, 2'd1, 4'd7}) begin
      failures++; $display("FAIL hit_beats_wall got %b exp %b", obs, {1'b0, 2'd1, 4'd7});
    end
  endtask
  task automatic test_serve_and_apply_edge();
    frame(5, -1, 3'd2, 3'd0, -1, 0, 5);
    checks++;
    if (obs !== {1'b1, 2'd0, 4'd8}) begin
      failures++; $display("FAIL serve_beats_hit got %b exp %b", obs, {1'b1, 2'd0, 4'd8});
    end
    frame(14, -1, 3'd7, 3'd0, -1, 0, -1);
    checks++;
    if (obs !== {1'b1, 2'd0, 4'd8}) begin
      failures++; $display("FAIL hit_on_fall_held got %b exp %b", obs, {1'b1, 2'd0, 4'd8});
    end
    frame(-1, -1, 3'd0, 3'd0, -1, 0, -1);
    checks++;
    if (obs !== {1'b0, 2'd3, 4'd5}) begin
      failures++; $display("FAIL hit_on_fall_next got %b exp %b", obs, {1'b0, 2'd3, 4'd5});
    end
  endtask
  task automatic test_reset_midvblank();
    for (int c = 0; c < 18; c++) begin
      bus._vblank = (c < 14);
      bus.hit     = (c == 16);
      bus.vpad    = 3'd0;
      bus.vvid    = 1'b0;
      bus.serve   = 1'b0;
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== {1'b0, 2'd0, 4'd8}) begin
      failures++; $display("FAIL reset_async got %b exp %b", obs, {1'b0, 2'd0, 4'd8});
    end
    model_reset();
    tick();
    rst_n = 1'b1;
    frame(-1, -1, 3'd0, 3'd0, -1, 0, -1);
    checks++;
    if (obs !== {1'b0, 2'd0, 4'd8}) begin
      failures++; $display("FAIL reset_no_apply got %b exp %b", obs, {1'b0, 2'd0, 4'd8});
    end
  endtask
  task automatic test_random();
    for (int f = 0; f < 40; f++)
      frame(int'($urandom_range(0, 27)), int'($urandom_range(0, 27)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            int'($urandom_range(0, 22)), int'($urandom_range(1, 6)), int'($urandom_range(0, 30)));
  endtask
  initial begin
    bus.hit = 1'b0; bus.serve = 1'b0; bus._vblank = 1'b1; bus.vvid = 1'b0; bus.vpad = 3'd0;
    model_reset();
    test_reset();
    test_hit_apply();
    test_wall();
    test_double_hit();
    test_serve_and_apply_edge();
    test_reset_midvblank();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
